// File: rtl/cordic_byte_sequencer.sv
// rtl/cordic_byte_sequencer.sv - byte-serial operand/result sequencer for the CORDIC magnitude/phase core
// Optional watchdog on the WAIT state: define CORDIC_SEQ_TIMEOUT_EN.
module cordic_byte_sequencer #(
  parameter int WIDTH          = 16,
  parameter int PHASE_W        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               core_start,
  output logic [WIDTH-1:0]   core_x,
  output logic [WIDTH-1:0]   core_y,
  input  logic               core_done,
  input  logic [WIDTH-1:0]   core_mag,
  input  logic [PHASE_W-1:0] core_phase,
  output logic               busy,
  output logic               err
);

  localparam int NIN  = 2 * WIDTH / 8;
  localparam int NOUT = (WIDTH + PHASE_W) / 8;
  localparam int NMAX = (NIN > NOUT) ? NIN : NOUT;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int RW   = WIDTH + PHASE_W;

  typedef enum logic [1:0] {S_RX, S_START, S_WAIT, S_TX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] opnd;
  logic [RW-1:0]      res;
  logic [2*WIDTH-1:0] opnd_next;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wdog;
`else
  // Watchdog compiled out: err is a constant 0 for any legal TIMEOUT_CYCLES.
  assign err = (TIMEOUT_CYCLES < 0);
`endif

  // Bytes enter at the top; after NIN shifts the first byte (X LSB) sits at bit 0.
  assign opnd_next = {in_data, opnd[2*WIDTH-1:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RX;
      cnt        <= '0;
      opnd       <= '0;
      res        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      core_start <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
      busy       <= 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
      wdog       <= '0;
      err        <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state)
        S_RX: begin
          if (in_valid) begin
            opnd <= opnd_next;
            busy <= 1'b1;
            if (cnt == CW'(NIN - 1)) begin
              cnt        <= '0;
              state      <= S_START;
              in_ready   <= 1'b0;
              core_start <= 1'b1;
              core_x     <= opnd_next[WIDTH-1:0];
              core_y     <= opnd_next[2*WIDTH-1:WIDTH];
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
`ifdef CORDIC_SEQ_TIMEOUT_EN
          wdog  <= '0;
`endif
        end
        S_WAIT: begin
          if (core_done) begin
            res       <= {core_phase, core_mag};
            out_data  <= core_mag[7:0];
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= S_TX;
          end
`ifdef CORDIC_SEQ_TIMEOUT_EN
          else if (wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
            state    <= S_RX;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            wdog <= wdog + WDW'(1);
          end
`endif
        end
        S_TX: begin
          if (out_ready) begin
            res      <= res >> 8;
            out_data <= res[15:8];
            if (cnt == CW'(NOUT - 1)) begin
              cnt       <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= S_RX;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= S_RX;
      endcase
    end
  end

endmodule

// File: doc/cordic_byte_sequencer.md
Name: cordic_byte_sequencer

Overview:
Byte-serial front-end controller for the CORDIC magnitude/phase core inside the TinyTapeout wrapper. It collects X/Y operands one byte at a time over a valid/ready handshake and launches the core with a single-cycle start pulse. It captures the core's magnitude and phase when the core reports done, then streams the results out byte by byte over a second valid/ready handshake. It owns all sequencing between the 8-bit pins and the WIDTH-bit core.

Parameters:
- WIDTH, 16, operand and magnitude width in bits; multiple of 8, range 8..32.
- PHASE_W, 32, phase result width in bits; multiple of 8.
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles; used only when CORDIC_SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- out_data  out  8  result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- core_start  out  1  one-cycle launch pulse to the CORDIC core.
- core_x  out  WIDTH  signed X operand, held stable from core_start until core_done.
- core_y  out  WIDTH  signed Y operand, held stable from core_start until core_done.
- core_done  in  1  core result valid, single-cycle pulse.
- core_mag  in  WIDTH  core magnitude, valid when core_done is high.
- core_phase  in  PHASE_W  core phase, valid when core_done is high.
- busy  out  1  high in every state except RX with zero bytes received.
- err  out  1  sticky timeout flag; tied 0 when the feature is compiled out.

Behaviour:
- Byte counts: NIN = 2*WIDTH/8; NOUT = (WIDTH+PHASE_W)/8. Defaults are 4 and 6.
- Input byte order: X LSB first through X MSB, then Y LSB first through Y MSB.
- Output byte order: mag LSB..MSB, then phase LSB..MSB.
- Reset values: state RX, byte counter 0, in_ready=1, out_valid=0, out_data=0, core_start=0, core_x=0, core_y=0, busy=0, err=0.
- Input transfer happens when in_valid && in_ready at a posedge. Output transfer happens when out_valid && out_ready at a posedge.
- RX state:
  - in_ready=1.
  - Each accepted byte shifts into the X/Y operand register at the position given by the counter, then the counter increments.
  - On the NIN-th byte, go to START.
- START state:
  - in_ready=0, core_start=1 for exactly one cycle.
  - core_x and core_y are driven from the operand register.
  - Next state: WAIT.
- WAIT state:
  - in_ready=0.
  - On core_done=1, capture core_mag and core_phase into the result shift register, go to TX, and clear the counter.
  - A core_done seen in any other state is ignored.
- TX state:
  - out_valid=1; out_data is the lowest byte of the result register.
  - On each transfer, shift right by 8 and increment the counter.
  - After the NOUT-th transfer: out_valid=0 on the next cycle, return to RX with counter 0.
  - While out_ready=0, out_data and out_valid hold stable.
- Latency:
  - core_start is high the cycle after the last input byte is accepted.
  - out_valid rises the cycle after core_done.
- in_valid outside RX: ignored, nothing stored.
- Back-to-back: in_ready is 1 again in the first cycle after the last output transfer.
- Asynchronous reset at any point (mid-RX, WAIT or TX):
  - Immediately forces all reset values and discards partial operands or results.
  - A core_done arriving after reset is ignored.

Optional Feature:
CORDIC_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES without core_done, return to RX with counter 0, set err=1, and emit no output bytes.
  - err clears only on reset.
- Not defined:
  - No watchdog logic is built; WAIT waits indefinitely.
  - err is constant 0.

Test Plan:
1. Basic transaction:
   - Stimulus: reset, then bytes E0 2E 40 1F (X=12000, Y=8000); core model returns mag=0x3A98, phase=0x12345678, 3 cycles after start.
   - Required response: core_x=0x2EE0, core_y=0x1F40 at the core_start pulse; out bytes 98 3A 78 56 34 12, in order.
2. Negative operands:
   - Stimulus: bytes 68 C5 10 27 (X=-15000, Y=10000).
   - Required response: core_x=0xC568, core_y=0x2710; exactly one core_start pulse.
3. Output backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles at each output byte.
   - Required response: out_data stable while stalled; no byte lost or duplicated; in_ready=0 until the 6th transfer.
4. Stray input and done:
   - Stimulus: in_valid=1 with byte AA during WAIT and TX; spurious core_done while in RX.
   - Required response: operands unchanged, no state change; the next transaction is correct.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 after 2 input bytes; release; send a full new 4-byte transaction.
   - Required response: outputs at reset values immediately; the new operands are used, not the stale bytes.
6. Timeout (CORDIC_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=20):
   - Stimulus: the core never asserts core_done.
   - Required response: after 20 cycles in WAIT, err=1, in_ready=1, out_valid never asserted.
